// File: rtl/fp_pkg.sv
// Shared types, flag positions and width helpers for the FP normalize/round stage.
// Width helpers take the unit's parameters so every file derives the same sizes.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_W         = 3;

    function automatic int bias(input int size_exponent);
        return (1 << (size_exponent - 1)) - 1;
    endfunction

    // carry + hidden + fraction + guard
    function automatic int mant_width(input int size_mantissa);
        return size_mantissa + 3;
    endfunction

    // two extra bits give a sign and headroom for +1 / -(SizeMantissa+1)
    function automatic int exp_int_width(input int size_exponent);
        return size_exponent + 2;
    endfunction

    function automatic int lz_width(input int size_mantissa);
        return $clog2(size_mantissa + 3);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Leading-zero count over carry, hidden and fraction bits; guard bit is not an input.
// Purely combinational; all-zero input yields SizeMantissa+2.
module leading_zero_counter
    import fp_pkg::*;
#(
    parameter int SizeMantissa = 23
) (
    input  logic [SizeMantissa+2:1]               mantissa,
    output logic [lz_width(SizeMantissa)-1:0]     lz
);

    localparam int LZW = lz_width(SizeMantissa);

    // Ascending scan: the highest set bit is the last one to write lz.
    always_comb begin
        lz = LZW'(SizeMantissa + 2);
        for (int i = 1; i <= SizeMantissa + 2; i++) begin
            if (mantissa[i]) begin
                lz = LZW'(SizeMantissa + 2 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round_unit.sv
// Normalizes an add/sub result, rounds to nearest-even and packs IEEE-754 with flags.
// Latency: result valid in the third cycle after the accept cycle; one op per 4 cycles min.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE.
module fp_normalize_round_unit
    import fp_pkg::*;
#(
    parameter int SizeMantissa = 23,
    parameter int SizeExponent = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sign,
    input  logic [SizeExponent-1:0]              in_exponent,
    input  logic [SizeMantissa+2:0]              in_mantissa,
    input  logic                                 in_sticky,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SizeExponent+SizeMantissa:0]   out_result,
    output logic [FLAG_W-1:0]                    out_flags
);

    localparam int MW  = mant_width(SizeMantissa);
    localparam int EW  = exp_int_width(SizeExponent);
    localparam int LZW = lz_width(SizeMantissa);
    localparam int RW  = SizeExponent + SizeMantissa + 1;

    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 * bias(SizeExponent) + 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    state_t                 state_q, state_d;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [MW-1:0]          mant_q;
    logic                   sticky_q;
    logic                   zero_q;

    logic [LZW-1:0]         lz;
    logic [LZW-1:0]         shift_amt;
    logic [MW-1:0]          norm_mant;
    logic signed [EW-1:0]   norm_exp;
    logic                   norm_sticky;
    logic                   norm_zero;

    logic                   guard, lsb, round_up, inexact;
    logic [SizeMantissa-1:0] frac, frac_rnd;
    logic signed [EW-1:0]   exp_rnd;
    logic [RW-1:0]          pack_result;
    logic [FLAG_W-1:0]      pack_flags;

    leading_zero_counter #(
        .SizeMantissa (SizeMantissa)
    ) u_lzc (
        .mantissa (mant_q[MW-1:1]),
        .lz       (lz)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = NORM;
            end
            NORM:  state_d = ROUND;
            ROUND: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // lz=0 means a carry-out: shift right once, old guard folds into sticky.
    always_comb begin
        shift_amt   = lz - LZW'(1);
        norm_mant   = mant_q;
        norm_exp    = exp_q;
        norm_sticky = sticky_q;
        norm_zero   = (mant_q == '0);
        if (lz == '0) begin
            norm_mant   = mant_q >> 1;
            norm_exp    = exp_q + EXP_ONE;
            norm_sticky = sticky_q | mant_q[0];
        end else if (lz > LZW'(1)) begin
            norm_mant   = mant_q << shift_amt;
            norm_exp    = exp_q - $signed({{(EW-LZW){1'b0}}, shift_amt});
        end
    end

    always_comb begin
        guard    = mant_q[0];
        lsb      = mant_q[1];
        frac     = mant_q[SizeMantissa:1];
        round_up = guard & (sticky_q | lsb);
        inexact  = guard | sticky_q;
        frac_rnd = frac;
        exp_rnd  = exp_q;
        if (round_up) begin
            if (&frac) begin
                frac_rnd = '0;
                exp_rnd  = exp_q + EXP_ONE;
            end else begin
                frac_rnd = frac + SizeMantissa'(1);
            end
        end

        pack_flags  = '0;
        pack_result = {sign_q, exp_rnd[SizeExponent-1:0], frac_rnd};
        if (zero_q) begin
            pack_result = {sign_q, {(RW-1){1'b0}}};
        end else if (exp_rnd >= EXP_MAX) begin
            pack_result = {sign_q, {SizeExponent{1'b1}}, {SizeMantissa{1'b0}}};
            pack_flags[FLAG_OVERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
            // no subnormal support: flush to signed zero
            pack_result = {sign_q, {(RW-1){1'b0}}};
            pack_flags[FLAG_UNDERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            pack_flags[FLAG_INEXACT] = inexact;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            sticky_q   <= 1'b0;
            zero_q     <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= $signed({{(EW-SizeExponent){1'b0}}, in_exponent});
                        mant_q   <= in_mantissa;
                        sticky_q <= in_sticky;
                    end
                end
                NORM: begin
                    mant_q   <= norm_mant;
                    exp_q    <= norm_exp;
                    sticky_q <= norm_sticky;
                    zero_q   <= norm_zero;
                end
                ROUND: begin
                    out_result <= pack_result;
                    out_flags  <= pack_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round_unit.sv
// Directed-vector bench for fp_normalize_round_unit: table of hand-computed results
// plus sequences for backpressure and mid-operation reset.
module tb_fp_normalize_round_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [25:0] in_mantissa;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [25:0] mant;
        logic        sticky;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    fp_normalize_round_unit #(
        .SizeMantissa (23),
        .SizeExponent (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exponent (in_exponent),
        .in_mantissa (in_mantissa),
        .in_sticky   (in_sticky),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_sign     = v.sign;
        in_exponent = v.exp;
        in_mantissa = v.mant;
        in_sticky   = v.sticky;
        in_valid    = 1'b1;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && !in_ready; n++) tick();
    endtask

    // Returns the number of edges from the accept edge to out_valid; 0 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            tick();
            if (c == 1) in_valid = 1'b0;
            if (out_valid) lat = c;
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        out_ready = 1'b1;
        wait_ready();
        drive(v);
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " result"}, out_result, v.res);
        check({tag, " flags"}, 32'(out_flags), 32'(v.flags));
        tick();
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_result"}, out_result, 32'd0);
        check({tag, " out_flags"}, 32'(out_flags), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] held_res;
        logic [2:0]  held_flags;

        vecs[0]  = '{1'b0, 8'd127, 26'h1000000, 1'b0, 32'h3F800000, 3'b000};
        vecs[1]  = '{1'b0, 8'd127, 26'h2000000, 1'b0, 32'h40000000, 3'b000};
        vecs[2]  = '{1'b0, 8'd127, 26'h0000002, 1'b0, 32'h34000000, 3'b000};
        vecs[3]  = '{1'b0, 8'd127, 26'h1FFFFFF, 1'b0, 32'h40000000, 3'b001};
        vecs[4]  = '{1'b0, 8'd127, 26'h1000001, 1'b0, 32'h3F800000, 3'b001};
        vecs[5]  = '{1'b0, 8'd254, 26'h2000000, 1'b0, 32'h7F800000, 3'b101};
        vecs[6]  = '{1'b0, 8'd1,   26'h0800000, 1'b0, 32'h00000000, 3'b011};
        vecs[7]  = '{1'b1, 8'd127, 26'h0000000, 1'b0, 32'h80000000, 3'b000};
        vecs[8]  = '{1'b0, 8'd127, 26'h1000003, 1'b0, 32'h3F800002, 3'b001};
        vecs[9]  = '{1'b0, 8'd127, 26'h1000000, 1'b1, 32'h3F800000, 3'b001};
        vecs[10] = '{1'b0, 8'd127, 26'h1000001, 1'b1, 32'h3F800001, 3'b001};
        vecs[11] = '{1'b1, 8'd128, 26'h1000000, 1'b0, 32'hC0000000, 3'b000};
        vecs[12] = '{1'b0, 8'd127, 26'h2000003, 1'b0, 32'h40000001, 3'b001};
        vecs[13] = '{1'b0, 8'd254, 26'h1FFFFFF, 1'b0, 32'h7F800000, 3'b101};
        vecs[14] = '{1'b0, 8'd127, 26'h0000001, 1'b0, 32'h33800000, 3'b000};
        vecs[15] = '{1'b0, 8'd10,  26'h0000002, 1'b0, 32'h00000000, 3'b011};

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = '0;
        in_mantissa = '0;
        in_sticky   = 1'b0;
        out_ready   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held in DONE while a second request waits.
        out_ready = 1'b0;
        wait_ready();
        drive(vecs[1]);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd3);
        held_res   = out_result;
        held_flags = out_flags;
        check("bp result", held_res, vecs[1].res);
        drive(vecs[3]);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp hold%0d valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d result", k), out_result, vecs[1].res);
            check($sformatf("bp hold%0d flags", k), 32'(out_flags), 32'(vecs[1].flags));
            check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp handshake valid", 32'(out_valid), 32'd0);
        check("bp handshake in_ready", 32'(in_ready), 32'd1);
        check("bp retained result", out_result, held_res);
        wait_valid(lat);
        check("bp second latency", 32'(lat), 32'd3);
        check("bp second result", out_result, vecs[3].res);
        check("bp second flags", 32'(out_flags), 32'(vecs[3].flags));
        tick();

        // Reset while in NORM.
        wait_ready();
        drive(vecs[5]);
        tick();
        in_valid = 1'b0;
        check("norm busy in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_norm");
        run_op(vecs[0], "after rst_norm");

        // Reset while in DONE with backpressure.
        out_ready = 1'b0;
        wait_ready();
        drive(vecs[11]);
        wait_valid(lat);
        check("done reach", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_done");
        run_op(vecs[12], "after rst_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
